// File: rtl/serial_mem_arbiter.sv
// Byte-serial RAM controller arbitrating an instruction-fetch port and a load/store port.
// Each access is split into little-endian byte transfers on an 8-bit bus.
module serial_mem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_flush,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_done,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_done,
   output logic              busy
);

   localparam int unsigned NB = DATA_W / 8;
   localparam int unsigned CW = $clog2(NB + 1);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e            state_q;
   logic [CW-1:0]     k_q;
   logic [CW-1:0]     n_q;
   logic              owner_q;      // 1 = data port owns the transfer
   logic              last_data_q;  // round-robin pointer: last port served was data
   logic              flushed_q;
   logic [DATA_W-1:0] wbuf_q;
   logic [DATA_W-1:0] rbuf_q;
   logic [7:0]        mem_dout_q;
   logic [ADDR_W-1:0] mem_a_q;
   logic              mem_wr_q;
   logic              inst_done_q;
   logic              data_done_q;
   logic [DATA_W-1:0] inst_rdata_q;
   logic [DATA_W-1:0] data_rdata_q;

   logic              inst_ok;
   logic              grant_data;
   logic              any_req;
   int unsigned       data_nb;
   logic [CW-1:0]     acc_n;
   logic [DATA_W-1:0] rd_cap;
   logic              last_rd;
   logic              last_wr;

   assign inst_ok = inst_req & ~inst_flush;
   assign any_req = data_req | inst_ok;
   assign last_rd = (k_q == n_q);
   assign last_wr = (k_q + CW'(1) == n_q);

   always_comb begin
      grant_data = data_req;
      if (data_req && inst_ok && ARB_MODE != 0) grant_data = ~last_data_q;
   end

   always_comb begin
      data_nb = 32'd1 << data_size;
      if (data_nb > NB) data_nb = NB;
      acc_n = grant_data ? CW'(data_nb) : CW'(NB);
   end

   // mem_din always carries the byte addressed one active cycle earlier, i.e. byte k-1
   always_comb begin
      rd_cap = rbuf_q;
      for (int i = 0; i < int'(NB); i++) begin
         if (i + 1 == int'(k_q)) rd_cap[8*i +: 8] = mem_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         k_q          <= '0;
         n_q          <= '0;
         owner_q      <= 1'b0;
         last_data_q  <= 1'b1;
         flushed_q    <= 1'b0;
         wbuf_q       <= '0;
         rbuf_q       <= '0;
         mem_dout_q   <= '0;
         mem_a_q      <= '0;
         mem_wr_q     <= 1'b0;
         inst_done_q  <= 1'b0;
         data_done_q  <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         // Flush is an event, so it is recorded even while the bus is stalled
         if (state_q == StRd && !owner_q && inst_flush) flushed_q <= 1'b1;
         if (rdy) begin
            unique case (state_q)
               StIdle: begin
                  if (any_req) begin
                     owner_q     <= grant_data;
                     last_data_q <= grant_data;
                     n_q         <= acc_n;
                     k_q         <= '0;
                     rbuf_q      <= '0;
                     flushed_q   <= 1'b0;
                     mem_a_q     <= grant_data ? data_addr : inst_addr;
                     if (grant_data && data_we) begin
                        state_q    <= StWr;
                        mem_wr_q   <= 1'b1;
                        mem_dout_q <= data_wdata[7:0];
                        wbuf_q     <= data_wdata >> 8;
                     end else begin
                        state_q <= StRd;
                     end
                  end
               end
               StRd: begin
                  if (last_rd) begin
                     state_q <= StDone;
                     if (owner_q) begin
                        data_rdata_q <= rd_cap;
                        data_done_q  <= 1'b1;
                     end else if (!(flushed_q || inst_flush)) begin
                        inst_rdata_q <= rd_cap;
                        inst_done_q  <= 1'b1;
                     end
                  end else begin
                     rbuf_q <= rd_cap;
                     k_q    <= k_q + CW'(1);
                     if (k_q + CW'(1) != n_q) mem_a_q <= mem_a_q + ADDR_W'(1);
                  end
               end
               StWr: begin
                  if (last_wr) begin
                     state_q     <= StDone;
                     mem_wr_q    <= 1'b0;
                     data_done_q <= 1'b1;
                  end else begin
                     k_q        <= k_q + CW'(1);
                     mem_a_q    <= mem_a_q + ADDR_W'(1);
                     mem_dout_q <= wbuf_q[7:0];
                     wbuf_q     <= wbuf_q >> 8;
                  end
               end
               StDone: begin
                  state_q     <= StIdle;
                  inst_done_q <= 1'b0;
                  data_done_q <= 1'b0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // A stalled cycle must neither write RAM nor be mistaken for the completion cycle
   assign mem_wr     = mem_wr_q & rdy;
   assign inst_done  = inst_done_q & rdy;
   assign data_done  = data_done_q & rdy;
   assign mem_a      = mem_a_q;
   assign mem_dout   = mem_dout_q;
   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: doc/serial_mem_arbiter.md
# serial_mem_arbiter

Parametrised byte-serial memory controller between the core's instruction-fetch and load/store units and the 8-bit external RAM bus. It arbitrates two requesters: an instruction read port and a data read/write port with byte, half and word sizes. It splits each access into little-endian byte transfers and reassembles read data. It supports fixed or round-robin arbitration, a global `rdy` stall, and cancellation of in-flight instruction fetches.

## Interface
- `ADDR_W`, 32: address width of all ports and `mem_a`.
- `DATA_W`, 32: requester data width. Must be a multiple of 8, ≥ 8. `NB = DATA_W/8`.
- `ARB_MODE`, 0: 0 = data port always wins; 1 = round-robin between ports.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable. Low = freeze.
- `mem_din` in 8: RAM read data, valid the cycle after `mem_a`.
- `mem_dout` out 8: RAM write data.
- `mem_a` out ADDR_W: RAM byte address.
- `mem_wr` out 1: 1 = write this cycle.
- `inst_req` in 1: fetch request (level; held until `inst_done` or flush).
- `inst_addr` in ADDR_W: fetch address. Always NB bytes.
- `inst_flush` in 1: cancel pending or in-flight fetch.
- `inst_rdata` out DATA_W: fetched word.
- `inst_done` out 1: one-cycle completion pulse.
- `data_req` in 1: data request (level; held until `data_done`).
- `data_we` in 1: 1 = store, 0 = load.
- `data_size` in 2: bytes = 1<<size, clamped to NB.
- `data_addr` in ADDR_W: data address.
- `data_wdata` in DATA_W: store data, low bytes used.
- `data_rdata` out DATA_W: load data, zero-extended.
- `data_done` out 1: one-cycle completion pulse.
- `busy` out 1: high in any state but IDLE.

## Operation
- States: IDLE, RD, WR, DONE.
- Reset: state IDLE, all outputs 0 (`mem_a`, `mem_dout`, `mem_wr`, `inst_rdata`, `data_rdata`, both dones, `busy`), RR pointer = data.
- IDLE:
  - Samples requests and latches owner, we, address, byte count N and write data.
  - Goes to RD or WR. Stays IDLE if there is no request.
  - A fetch with `inst_flush` high is not accepted.
- Arbitration:
  - ARB_MODE 0: data wins whenever both request.
  - ARB_MODE 1: the port not served last wins a tie. The pointer updates on accept.
- RD: byte counter k = 0..N-1.
  - Drive `mem_a` = base+k, `mem_wr` = 0.
  - Capture `mem_din` into byte k-1 of the result.
  - One extra cycle captures the last byte, then go to DONE.
- WR: for each k, drive `mem_a` = base+k, `mem_dout` = wdata[8k+7:8k], `mem_wr` = 1. After byte N-1, go to DONE.
- DONE:
  - Pulse the owner's done for one cycle, with rdata stable.
  - Then `mem_wr` = 0 and return to IDLE.
  - The requester drops req on the done edge.
- rdata: bytes beyond N are 0 and hold until the next completion for that port.
- Address arithmetic: base+k wraps modulo 2^ADDR_W.
- `rdy` low:
  - State, counter, capture registers and `mem_a` are all held; `mem_wr` is forced 0.
  - No `mem_din` capture. The held address re-presents the same byte.
  - On resume, the stalled byte is re-issued or re-captured.
- `inst_flush` during an owned fetch:
  - The bus sequence runs to completion, so RAM is never left mid-burst.
  - `inst_done` is suppressed and `inst_rdata` is not updated.
- Reset mid-transfer: immediate return to reset values. No completion.

## Timing
- Accept edge = E0.
- Read: byte k address in cycle k+1, data captured end of cycle k+2. Done in cycle N+2.
- Read latency: NB+2 cycles, i.e. 6 cycles for a 32-bit word.
- Write: byte k in cycle k+1. Done in cycle N+1. Latency is 5 cycles for a word, 2 for a byte.
- Back-to-back transactions: one IDLE cycle between DONE and the next address.
- Stalls add exactly one cycle per `rdy`-low cycle.
- Requests are sampled only in IDLE. A request changing mid-transaction is ignored until the next IDLE.

## Test plan
- Word load, ARB_MODE 0: `data_addr`=0x100, RAM holds 0x11,0x22,0x33,0x44 → `mem_a` 0x100..0x103 in cycles 1-4, `data_rdata`=0x44332211, `data_done` high in cycle 6 only.
- Byte and half stores:
  - size 0 with 0xAABBCCDD at 0x20 → a single write of 0xDD at 0x20, done in cycle 2.
  - size 1 → writes 0xDD at 0x20 and 0xCC at 0x21, done in cycle 3.
- Simultaneous requests:
  - ARB_MODE 0, both held → data served twice in a row if re-requested.
  - ARB_MODE 1, both held continuously → grants alternate inst, data, inst...
- Stall: `rdy` low for 3 cycles during word read byte 2 → `mem_a` held at base+2, `mem_wr` 0, result correct, done at cycle 9.
- Flush: `inst_flush` pulsed in cycle 2 of a fetch → 4 bus reads still occur, no `inst_done`, `inst_rdata` unchanged, `busy` falls after DONE.
- Reset: `rst_n` low during WR byte 1 → all outputs 0 asynchronously. After release, a new read at 0xFFFFFFFE wraps `mem_a` to 0x0,0x1 for bytes 2-3.
